// File: rtl/keypad_encoder_if.sv
// Keypad pins and security-FSM event bus around keypad_encoder.
interface keypad_encoder_if;
    logic [3:0] col_drive;
    logic [3:0] row_sense;
    logic [3:0] digit;
    logic       digit_enterd;
    logic [1:0] command;
    logic       busy;

    modport master (
        output col_drive,
        output digit,
        output digit_enterd,
        output command,
        output busy,
        input  row_sense
    );

    modport slave (
        input  col_drive,
        input  digit,
        input  digit_enterd,
        input  command,
        input  busy,
        output row_sense
    );
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner/debouncer producing one digit/command event per press.
// Define KEYPAD_REPEAT_EN to re-emit held numeric keys every REPEAT_DLY ticks.
module keypad_encoder #(
    parameter int unsigned SCAN_DIV   = 16,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned REPEAT_DLY = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    keypad_encoder_if.master kp
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] S_SCAN    = 2'd0;
    localparam logic [1:0] S_BOUNCE  = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    if (SCAN_DIV < 2 || DEBOUNCE < 1 || REPEAT_DLY < 1) begin : g_param_check
        $error("keypad_encoder: illegal parameter value");
    end

    logic [DIV_W-1:0] div_q;
    logic             tick_c;
    logic [1:0]       state_q, state_n;
    logic [3:0]       col_q, col_n;
    logic [1:0]       kr_q, kr_n, kc_q, kc_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             armed_q, armed_n, clean_q, clean_n;
    logic [3:0]       digit_q, digit_n;
    logic             enterd_q, enterd_n;
    logic [1:0]       cmd_q, cmd_n;
    logic             busy_q, busy_n;
`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned HOLD_W = $clog2(REPEAT_DLY + 1);
    logic [HOLD_W-1:0] hold_q, hold_n;
`endif

    logic       one_low_c;
    logic [1:0] row_idx_c, col_idx_c;
    logic [3:0] pat_c, rot_c;
    logic       key_num_c;
    logic [3:0] key_val_c;
    logic [1:0] key_cmd_c;

    // Free-running column-step divider
    assign tick_c = (div_q == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n)    div_q <= '0;
        else if (tick_c) div_q <= '0;
        else             div_q <= div_q + DIV_W'(1);
    end

    assign pat_c = ~(4'b0001 << kr_q);
    assign rot_c = {col_q[2:0], col_q[3]};

    always_comb begin
        one_low_c = 1'b1;
        row_idx_c = 2'd0;
        case (kp.row_sense)
            4'b1110: row_idx_c = 2'd0;
            4'b1101: row_idx_c = 2'd1;
            4'b1011: row_idx_c = 2'd2;
            4'b0111: row_idx_c = 2'd3;
            default: one_low_c = 1'b0;
        endcase
        case (col_q)
            4'b1101: col_idx_c = 2'd1;
            4'b1011: col_idx_c = 2'd2;
            4'b0111: col_idx_c = 2'd3;
            default: col_idx_c = 2'd0;
        endcase
    end

    // Layout decode of the latched (row,col)
    always_comb begin
        key_num_c = 1'b1;
        key_val_c = 4'd0;
        key_cmd_c = 2'd0;
        case ({kr_q, kc_q})
            4'd0:    key_val_c = 4'd1;
            4'd1:    key_val_c = 4'd2;
            4'd2:    key_val_c = 4'd3;
            4'd4:    key_val_c = 4'd4;
            4'd5:    key_val_c = 4'd5;
            4'd6:    key_val_c = 4'd6;
            4'd8:    key_val_c = 4'd7;
            4'd9:    key_val_c = 4'd8;
            4'd10:   key_val_c = 4'd9;
            4'd13:   key_val_c = 4'd0;
            4'd3:    begin key_num_c = 1'b0; key_cmd_c = 2'd1; end
            4'd7:    begin key_num_c = 1'b0; key_cmd_c = 2'd2; end
            default: key_num_c = 1'b0;
        endcase
    end

    // After reset a full clean sweep must pass before any press is accepted,
    // so a key held through reset has to be released and pressed again.
    always_comb begin
        state_n  = state_q;
        col_n    = col_q;
        kr_n     = kr_q;
        kc_n     = kc_q;
        cnt_n    = cnt_q;
        armed_n  = armed_q;
        clean_n  = clean_q;
        digit_n  = digit_q;
        enterd_n = 1'b0;
        cmd_n    = 2'd0;
`ifdef KEYPAD_REPEAT_EN
        hold_n   = hold_q;
`endif
        case (state_q)
            S_SCAN: if (tick_c) begin
                if (armed_q && one_low_c) begin
                    kr_n    = row_idx_c;
                    kc_n    = col_idx_c;
                    cnt_n   = CNT_W'(1);
                    state_n = S_BOUNCE;
                end else begin
                    col_n = rot_c;
                    if (!armed_q) begin
                        clean_n = clean_q & (kp.row_sense == 4'hF);
                        if (col_q == 4'b0111) begin
                            armed_n = clean_n;
                            clean_n = 1'b1;
                        end
                    end
                end
            end
            S_BOUNCE: if (tick_c) begin
                if (kp.row_sense == pat_c) begin
                    if (cnt_q == CNT_W'(DEBOUNCE)) state_n = S_EMIT;
                    else                           cnt_n   = cnt_q + CNT_W'(1);
                end else begin
                    state_n = S_SCAN;
                    col_n   = rot_c;
                end
            end
            S_EMIT: begin
                state_n = S_RELEASE;
                cnt_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                hold_n  = '0;
`endif
            end
            S_RELEASE: if (tick_c) begin
                if (kp.row_sense == 4'hF) begin
                    cnt_n = cnt_q + CNT_W'(1);
                    if (cnt_n == CNT_W'(DEBOUNCE)) state_n = S_SCAN;
`ifdef KEYPAD_REPEAT_EN
                    hold_n = '0;
`endif
                end else begin
                    cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
                    if (kp.row_sense == pat_c && key_num_c) begin
                        if (hold_q == HOLD_W'(REPEAT_DLY - 1)) state_n = S_EMIT;
                        else                                   hold_n  = hold_q + HOLD_W'(1);
                    end else begin
                        hold_n = '0;
                    end
`endif
                end
            end
            default: state_n = S_SCAN;
        endcase
        if (state_n == S_EMIT) begin
            enterd_n = key_num_c;
            digit_n  = key_num_c ? key_val_c : digit_q;
            cmd_n    = key_cmd_c;
        end
        busy_n = (state_n != S_SCAN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_SCAN;
            col_q    <= 4'b1110;
            kr_q     <= 2'd0;
            kc_q     <= 2'd0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            clean_q  <= 1'b1;
            digit_q  <= 4'd0;
            enterd_q <= 1'b0;
            cmd_q    <= 2'd0;
            busy_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            hold_q   <= '0;
`endif
        end else begin
            state_q  <= state_n;
            col_q    <= col_n;
            kr_q     <= kr_n;
            kc_q     <= kc_n;
            cnt_q    <= cnt_n;
            armed_q  <= armed_n;
            clean_q  <= clean_n;
            digit_q  <= digit_n;
            enterd_q <= enterd_n;
            cmd_q    <= cmd_n;
            busy_q   <= busy_n;
`ifdef KEYPAD_REPEAT_EN
            hold_q   <= hold_n;
`endif
        end
    end

    assign kp.col_drive    = col_q;
    assign kp.digit        = digit_q;
    assign kp.digit_enterd = enterd_q;
    assign kp.command      = cmd_q;
    assign kp.busy         = busy_q;
endmodule
